uninasoc_irq_ctrl: RTL and testbench
====================================

# uninasoc_irq_ctrl

Parametrised platform interrupt controller that collects `NUM_IRQ` external interrupt lines, synchronises them, latches them per-source as level- or edge-sensitive, masks them, and presents one prioritised request plus source ID to the RVM socket core. It sits on the AXI-Lite peripheral bus behind a simple single-cycle register port (bus bridge external). It replaces the fixed 3-line interrupt wiring with a configurable, claim/complete-managed block.

## Interface

Parameters:
- `NUM_IRQ`, 3: number of interrupt sources, legal 1..31.
- `SYNC_STAGES`, 2: synchroniser flops per source, legal 2..4.
- `ID_W`, `$clog2(NUM_IRQ+1)`: width of the source ID. ID 0 means none; source i has ID i+1.

Ports:
- `clock_i` in 1: system clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `irq_src_i` in `NUM_IRQ`: asynchronous interrupt sources.
- `reg_req_i` in 1: register access request, one access per asserted cycle.
- `reg_we_i` in 1: 1 = write, 0 = read.
- `reg_addr_i` in 3: word address.
- `reg_wdata_i` in 32: write data.
- `reg_rdata_o` out 32: read data, valid with `reg_ack_o`.
- `reg_ack_o` out 1: access completion.
- `irq_o` out 1: interrupt request to the core.
- `irq_id_o` out `ID_W`: ID of the highest-priority eligible source, 0 if none.

## Operation

- Per source, three bits: `pending`, `enable`, `in_service`. `mode` is per source, 1 = edge, and is present only with `IRQ_CTRL_EDGE_EN`.
- Synchroniser: `SYNC_STAGES` flops followed by a delayed copy `sync_d`.
- `pending` update each cycle:
  - Level source: `pending <= sync`.
  - Edge source: `pending <= (pending & ~clr) | (sync & ~sync_d)`.
  - If a set and a clear hit the same cycle, the set wins.
- Eligible = `pending & enable & ~in_service`.
- Priority: lowest index wins.
- `irq_o` = OR of eligible. `irq_id_o` = ID of the winner. Both are registered.
- Register map (word address):
  - 0 PENDING: read returns pending bits. A write is W1C on edge sources and ignored on level sources.
  - 1 ENABLE: read/write, bits ≥ `NUM_IRQ` read 0.
  - 2 MODE: read/write.
  - 3 CLAIM, read only:
    - Returns the current winner ID, zero-extended.
    - Sets `in_service[winner]` and clears `pending[winner]` if the winner is edge.
    - With no eligible source: returns 0, no state change.
  - 4 COMPLETE, write only: `wdata[ID_W-1:0]` = ID, clears that `in_service` bit. ID 0, ID > `NUM_IRQ`, or a source not in service: ignored.
  - 5..7: read 0, writes ignored.
- A level source stays masked while in service. It re-raises after COMPLETE if still high.

## Timing

- Reset values: all pending, enable, mode, in_service and synchroniser flops are 0; `irq_o`=0, `irq_id_o`=0, `reg_ack_o`=0, `reg_rdata_o`=0.
- Reset asserted mid-operation clears all state, including in-service, on the next edge.
- A source held high across reset release is seen as a rising edge.
- Input latency: `irq_src_i` first sampled high at edge 0 → `pending` set at edge `SYNC_STAGES` → `irq_o`/`irq_id_o` high after edge `SYNC_STAGES+1`. This holds for both modes.
- Register port:
  - `reg_req_i` sampled at edge n → `reg_ack_o`=1 and `reg_rdata_o` valid during cycle n+1. `reg_rdata_o` is 0 for writes.
  - Back-to-back requests are accepted every cycle. There is no stall.
- Register side effects (writes, CLAIM) commit at edge n. `irq_o`/`irq_id_o` reflect them after edge n+1.
- CLAIM reads the registered winner as it stands at edge n.

## Configuration

- `IRQ_CTRL_EDGE_EN` defined: `mode` register implemented, edge detection and W1C active.
- `IRQ_CTRL_EDGE_EN` undefined:
  - No `mode` flops or `sync_d`; all sources are level.
  - MODE reads 0 and writes are ignored. PENDING writes are ignored.
  - Latency is unchanged.

## Test plan

- Reset: hold `reset_i` 3 cycles with `irq_src_i`=all-1 → all outputs 0. Read ENABLE → 0, `reg_ack_o` one cycle after request.
- Latency: `SYNC_STAGES`=2, ENABLE=0x1, raise `irq_src_i[0]` at edge 0 → `irq_o`=1, `irq_id_o`=1 after edge 3, not earlier.
- Priority/claim:
  - Setup: ENABLE=0x7, sources 1 and 2 high, level.
  - `irq_id_o`=2. CLAIM returns 2 → `irq_id_o`=3 two cycles later.
  - Second CLAIM returns 3 → `irq_o`=0.
  - COMPLETE 2 → `irq_id_o`=2 again.
- Edge with `IRQ_CTRL_EDGE_EN`: MODE=0x1, 1-cycle pulse on source 0 → PENDING reads 0x1 and stays after the pulse. CLAIM returns 1, then PENDING=0. A new pulse on the same cycle as CLAIM leaves PENDING=1.
- Boundaries:
  - COMPLETE with ID 0, with ID `NUM_IRQ`+1, and on an idle source → no state change.
  - CLAIM with nothing eligible returns 0.
  - Reads of addresses 5..7 return 0.
  - Reset asserted while source 0 is in service → after release with source 0 high, `irq_id_o`=1.

Source files
------------

// File: rtl/uninasoc_irq_ctrl.sv
// uninasoc_irq_ctrl: synchronised, maskable, lowest-index-priority interrupt controller with claim/complete.
// Optional build macro IRQ_CTRL_EDGE_EN adds per-source edge mode (MODE register) and PENDING W1C.
module uninasoc_irq_ctrl #(
  parameter int NUM_IRQ     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_IRQ + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [2:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_ack_o,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o
);
  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_ENABLE   = 3'd1;
  localparam logic [2:0] ADDR_MODE     = 3'd2;
  localparam logic [2:0] ADDR_CLAIM    = 3'd3;
  localparam logic [2:0] ADDR_COMPLETE = 3'd4;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_pending, r_enable, r_in_service;
  logic [NUM_IRQ-1:0] w_sync, w_mode, w_rise, w_clr;
  logic [NUM_IRQ-1:0] w_claim_set, w_complete_clr, w_eligible, w_pending_next;
  logic               r_irq, r_ack;
  logic [ID_W-1:0]    r_id, w_id;
  logic [31:0]        r_rdata, w_rdata;
  logic               w_rd, w_wr, w_claim, w_unused;

  assign w_rd     = reg_req_i & ~reg_we_i;
  assign w_wr     = reg_req_i & reg_we_i;
  assign w_claim  = w_rd && (reg_addr_i == ADDR_CLAIM) && (r_id != '0);
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_unused = &{1'b0, reg_wdata_i};

  always_ff @(posedge clock_i) begin
    if (reset_i) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], irq_src_i};
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] r_mode, r_sync_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_mode   <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync_d <= w_sync;
      if (w_wr && (reg_addr_i == ADDR_MODE)) r_mode <= reg_wdata_i[NUM_IRQ-1:0];
    end
  end

  assign w_mode = r_mode;
  assign w_rise = w_sync & ~r_sync_d;
  assign w_clr  = ((w_wr && (reg_addr_i == ADDR_PENDING)) ? reg_wdata_i[NUM_IRQ-1:0] : '0)
                | w_claim_set;
`else
  assign w_mode = '0;
  assign w_rise = '0;
  assign w_clr  = '0;
`endif

  // Edge sources hold until cleared, a same-cycle rise beats the clear; level sources track sync.
  assign w_pending_next = (w_mode & ((r_pending & ~w_clr) | w_rise)) | (~w_mode & w_sync);
  assign w_eligible     = r_pending & r_enable & ~r_in_service;

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      assign w_claim_set[gi]    = w_claim && (r_id == ID_W'(gi + 1));
      assign w_complete_clr[gi] = w_wr && (reg_addr_i == ADDR_COMPLETE)
                                  && (reg_wdata_i[ID_W-1:0] == ID_W'(gi + 1));
    end
  endgenerate

  always_comb begin
    w_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_id = ID_W'(i + 1);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (reg_addr_i)
        ADDR_PENDING: w_rdata[NUM_IRQ-1:0] = r_pending;
        ADDR_ENABLE:  w_rdata[NUM_IRQ-1:0] = r_enable;
        ADDR_MODE:    w_rdata[NUM_IRQ-1:0] = w_mode;
        ADDR_CLAIM:   w_rdata[ID_W-1:0]    = r_id;
        default:      w_rdata              = '0;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_pending    <= '0;
      r_enable     <= '0;
      r_in_service <= '0;
      r_irq        <= 1'b0;
      r_id         <= '0;
      r_ack        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_wr && (reg_addr_i == ADDR_ENABLE)) r_enable <= reg_wdata_i[NUM_IRQ-1:0];
      r_in_service <= (r_in_service | w_claim_set) & ~w_complete_clr;
      r_irq        <= |w_eligible;
      r_id         <= w_id;
      r_ack        <= reg_req_i;
      r_rdata      <= w_rdata;
    end
  end

  assign irq_o       = r_irq;
  assign irq_id_o    = r_id;
  assign reg_ack_o   = r_ack;
  assign reg_rdata_o = r_rdata;
endmodule

// File: tb/tb_uninasoc_irq_ctrl.sv
// Bench for uninasoc_irq_ctrl: directed scenarios plus random traffic, all checked every cycle
// against a sample-history reference model; IRQ_CTRL_EDGE_EN adds the edge-mode scenario.
module tb_uninasoc_irq_ctrl;
  localparam int N  = 3;
  localparam int S  = 2;
  localparam int IW = $clog2(N + 1);
`ifdef IRQ_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src;
  logic          req, we;
  logic [2:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack, irq;
  logic [IW-1:0] id;

  int total = 0;
  int bad   = 0;

  uninasoc_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .irq_src_i  (src),
    .reg_req_i  (req),
    .reg_we_i   (we),
    .reg_addr_i (addr),
    .reg_wdata_i(wdata),
    .reg_rdata_o(rdata),
    .reg_ack_o  (ack),
    .irq_o      (irq),
    .irq_id_o   (id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state. m_hist[j] is the source sample taken j+1 edges ago,
  // so the synchronised view at an edge is the sample from S edges back.
  bit          m_pend[N], m_en[N], m_mode[N], m_ins[N];
  bit [N-1:0]  m_hist[S+1];
  bit          m_irq, m_ack;
  int          m_id;
  bit [31:0]   m_rdata;

  task automatic model_step();
    int win, cid, cmp_id;
    bit is_rd, is_wr, rise, clr;
    bit [N-1:0] now_sync, old_sync;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_ins[i] = 0;
      end
      for (int j = 0; j <= S; j++) m_hist[j] = '0;
      m_irq = 0; m_id = 0; m_ack = 0; m_rdata = 0;
      return;
    end
    is_rd    = req && !we;
    is_wr    = req && we;
    now_sync = m_hist[S-1];
    old_sync = m_hist[S];
    win = 0;
    for (int i = N - 1; i >= 0; i--)
      if (m_pend[i] && m_en[i] && !m_ins[i]) win = i + 1;
    cid    = (is_rd && addr == 3) ? m_id : 0;
    cmp_id = (is_wr && addr == 4) ? int'(wdata % (32'd1 << IW)) : 0;
    m_ack   = req;
    m_rdata = 0;
    if (is_rd) begin
      case (addr)
        3'd0: for (int i = 0; i < N; i++) m_rdata[i] = m_pend[i];
        3'd1: for (int i = 0; i < N; i++) m_rdata[i] = m_en[i];
        3'd2: for (int i = 0; i < N; i++) m_rdata[i] = m_mode[i];
        3'd3: m_rdata = 32'(m_id);
        default: m_rdata = 0;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        rise = now_sync[i] && !old_sync[i];
        clr  = (is_wr && addr == 0 && wdata[i]) || (cid == i + 1);
        if (rise)     m_pend[i] = 1;
        else if (clr) m_pend[i] = 0;
      end else begin
        m_pend[i] = now_sync[i];
      end
      if (is_wr && addr == 1) m_en[i] = wdata[i];
      if (EDGE && is_wr && addr == 2) m_mode[i] = wdata[i];
      if (cid == i + 1)    m_ins[i] = 1;
      if (cmp_id == i + 1) m_ins[i] = 0;
    end
    m_irq = (win != 0);
    m_id  = win;
    for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = src;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("irq_o", 32'(irq), 32'(m_irq));
    chk("irq_id_o", 32'(id), 32'(m_id));
    chk("reg_ack_o", 32'(ack), 32'(m_ack));
    chk("reg_rdata_o", rdata, m_rdata);
    if (req && !rst)
      $display("txn %s addr=%0d wdata=0x%0h rdata=0x%0h irq=%0b id=%0d",
               we ? "wr" : "rd", addr, wdata, rdata, irq, id);
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a; wdata = $urandom;
    tick();
    d = rdata;
    req = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] v);
    req = 1'b1; we = 1'b1; addr = a; wdata = v;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    rst = 1'b1; src = '1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(id), 0);
    chk("rst_ack", 32'(ack), 0);
    rst = 1'b0; src = '0;
    tick();
    do_read(3'd1, d);
    chk("rst_enable", d, 0);
    chk("rst_rd_ack", 32'(ack), 1);
    tick();
    chk("ack_drop", 32'(ack), 0);

    // Input latency: edge 0 samples the source, irq visible after edge S+1.
    do_write(3'd1, 32'h1);
    repeat (3) tick();
    src = 3'b001;
    for (int e = 0; e <= S; e++) begin
      tick();
      chk("lat_early", 32'(irq), 0);
    end
    tick();
    chk("lat_irq", 32'(irq), 1);
    chk("lat_id", 32'(id), 1);

    // Priority and claim/complete with level sources 1 and 2.
    src = '0;
    do_write(3'd1, 32'h7);
    repeat (5) tick();
    src = 3'b110;
    repeat (5) tick();
    chk("prio_id", 32'(id), 2);
    do_read(3'd3, d);
    chk("claim1", d, 2);
    tick();
    chk("after_claim1_id", 32'(id), 3);
    do_read(3'd3, d);
    chk("claim2", d, 3);
    tick();
    chk("after_claim2_irq", 32'(irq), 0);
    do_write(3'd4, 32'd2);
    tick();
    chk("complete2_id", 32'(id), 2);

    // Ignored completes must not release source 2 (ID 3).
    do_write(3'd4, 32'd0);
    do_write(3'd4, 32'(N + 1));
    do_write(3'd4, 32'd1);
    do_read(3'd3, d);
    chk("claim3", d, 2);
    tick();
    chk("bogus_complete_irq", 32'(irq), 0);
    do_read(3'd3, d);
    chk("claim_none", d, 0);
    do_write(3'd4, 32'd2);
    do_write(3'd4, 32'd3);
    for (int a = 5; a < 8; a++) begin
      do_read(3'(a), d);
      chk("hole_read", d, 0);
    end

    // Reset while source 0 is in service.
    src = 3'b001;
    do_write(3'd1, 32'h1);
    repeat (5) tick();
    do_read(3'd3, d);
    chk("claim_src0", d, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_write(3'd1, 32'h1);
    repeat (4) tick();
    chk("post_rst_id", 32'(id), 1);

`ifdef IRQ_CTRL_EDGE_EN
    src = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    do_write(3'd1, 32'h1);
    do_write(3'd2, 32'h1);
    repeat (4) tick();
    src = 3'b001; tick(); src = '0;
    repeat (4) tick();
    do_read(3'd0, d);
    chk("edge_pend", d, 1);
    repeat (3) tick();
    do_read(3'd0, d);
    chk("edge_pend_hold", d, 1);
    do_read(3'd3, d);
    chk("edge_claim", d, 1);
    do_read(3'd0, d);
    chk("edge_pend_clr", d, 0);
    do_write(3'd4, 32'd1);
    src = 3'b001; tick(); src = '0;
    repeat (5) tick();
    src = 3'b001; tick(); src = '0; tick();
    do_read(3'd3, d);
    chk("edge_claim2", d, 1);
    do_read(3'd0, d);
    chk("edge_set_wins", d, 1);
    do_write(3'd4, 32'd1);
    do_write(3'd0, 32'h1);
    do_read(3'd0, d);
    chk("edge_w1c", d, 0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) src = N'($urandom);
      req   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      if (addr == 3'd4) wdata = $urandom_range(0, N + 1);
      if (addr == 3'd3) we = 1'b0;
      tick();
    end
    rst = 1'b0; req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
